// File: rtl/intersection_traffic_model.sv
// Closed-loop plant for the 5-approach intersection. It keeps a car queue per approach,
// discharges on green, drives the controller's sensors and flags light-sequence faults.
module intersection_traffic_model #(
  parameter int QW          = 4,
  parameter int START_DELAY = 1,
  parameter int MAX_WAIT    = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      arrive,
  input  logic [1:0]      e_str_light,
  input  logic [1:0]      w_str_light,
  input  logic [1:0]      e_left_light,
  input  logic [1:0]      w_left_light,
  input  logic [1:0]      ns_light,
  output logic            e_str_sensor,
  output logic            w_str_sensor,
  output logic            e_left_sensor,
  output logic            w_left_sensor,
  output logic            ns_sensor,
  output logic [5*QW-1:0] q_count,
  output logic [15:0]     departed_total,
  output logic [4:0]      overflow,
  output logic            conflict_err,
  output logic [2:0]      conflict_code,
  output logic [4:0]      seq_err,
  output logic [4:0]      starve
);
  localparam int NUM_LANES = 5;
  localparam logic [1:0] YELLOW = 2'd1, GREEN = 2'd2;

  logic [NUM_LANES-1:0][1:0]    light;
  logic [NUM_LANES-1:0][QW-1:0] q;
  logic [NUM_LANES-1:0]         depart, nonred;
  logic [5:0]                   cpair;
  logic [2:0]                   ccode, dcnt;

  assign light = {ns_light, w_left_light, e_left_light, w_str_light, e_str_light};

  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      itm_lane #(.QW(QW), .START_DELAY(START_DELAY), .MAX_WAIT(MAX_WAIT)) u_lane (
        .clk      (clk),
        .reset    (reset),
        .arrive   (arrive[i]),
        .light    (light[i]),
        .q        (q[i]),
        .depart   (depart[i]),
        .overflow (overflow[i]),
        .seq_err  (seq_err[i]),
        .starve   (starve[i])
      );
      assign nonred[i] = (light[i] == YELLOW) || (light[i] == GREEN);
    end
  endgenerate

  assign q_count       = q;
  assign e_str_sensor  = |q[0];
  assign w_str_sensor  = |q[1];
  assign e_left_sensor = |q[2];
  assign w_left_sensor = |q[3];
  assign ns_sensor     = |q[4];

  // bit index == conflict code
  assign cpair = {nonred[4] & nonred[3], nonred[4] & nonred[2], nonred[4] & nonred[1],
                  nonred[4] & nonred[0], nonred[1] & nonred[2], nonred[0] & nonred[3]};

  always_comb begin
    ccode = '0;
    for (int p = 5; p >= 0; p--)
      if (cpair[p]) ccode = 3'(p);
  end

  always_comb begin
    dcnt = '0;
    for (int k = 0; k < NUM_LANES; k++) dcnt = dcnt + {2'b0, depart[k]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      departed_total <= '0;
      conflict_err   <= 1'b0;
      conflict_code  <= '0;
    end else begin
      departed_total <= departed_total + {13'b0, dcnt};
      if (!conflict_err && |cpair) begin
        conflict_err  <= 1'b1;
        conflict_code <= ccode;
      end
    end
  end
endmodule

// One approach: queue counter, green-age discharge gate, wait/starve timer, sequence check.
module itm_lane #(
  parameter int QW          = 4,
  parameter int START_DELAY = 1,
  parameter int MAX_WAIT    = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arrive,
  input  logic [1:0]    light,
  output logic [QW-1:0] q,
  output logic          depart,
  output logic          overflow,
  output logic          seq_err,
  output logic          starve
);
  localparam logic [1:0] RED = 2'd0, YELLOW = 2'd1, GREEN = 2'd2;
  localparam int GW = $clog2(START_DELAY + 2);
  localparam int WW = $clog2(MAX_WAIT + 2);
  localparam logic [GW-1:0] SD   = GW'(START_DELAY);
  localparam logic [WW-1:0] MW   = WW'(MAX_WAIT);
  localparam logic [QW-1:0] QMAX = '1;

  logic [GW-1:0] green_age;
  logic [WW-1:0] wait_cnt;
  logic [1:0]    prev_color;
  logic          green, red, legal;

  assign green  = (light == GREEN);
  assign red    = (light == RED);
  assign depart = green && (green_age >= SD) && (q != '0);

  always_comb begin
    legal = 1'b0;
    case ({prev_color, light})
      {RED, RED}, {RED, GREEN}, {GREEN, GREEN},
      {GREEN, YELLOW}, {YELLOW, YELLOW}, {YELLOW, RED}: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q          <= '0;
      green_age  <= '0;
      wait_cnt   <= '0;
      prev_color <= RED;
      overflow   <= 1'b0;
      seq_err    <= 1'b0;
      starve     <= 1'b0;
    end else begin
      if (!green)               green_age <= '0;
      else if (green_age != SD) green_age <= green_age + 1'b1;

      if ((q != '0) && red) begin
        if (wait_cnt != MW) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      starve     <= starve | (wait_cnt == MW);
      seq_err    <= seq_err | !legal;
      prev_color <= light;

      // simultaneous arrive and depart leave the count alone
      if (arrive && !depart) begin
        if (q == QMAX) overflow <= 1'b1;
        else           q <= q + 1'b1;
      end else if (!arrive && depart) begin
        q <= q - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_intersection_traffic_model.sv
// Directed plus randomized bench for intersection_traffic_model against a behavioural model.
module tb_intersection_traffic_model;
  localparam int QW = 4, SD = 1, MW = 8;
  localparam int QMAX = (1 << QW) - 1;
  localparam int R = 0, Y = 1, G = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [4:0]      arrive;
  logic [1:0]      lt [5];
  logic            e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor;
  logic [5*QW-1:0] q_count;
  logic [15:0]     departed_total;
  logic [4:0]      overflow, seq_err, starve;
  logic            conflict_err;
  logic [2:0]      conflict_code;

  int checks = 0, passed = 0, failed = 0;

  // reference state
  int mq [5], mg [5], mw [5], mprev [5];
  bit movf [5], mseq [5], mstarve [5];
  bit mcerr;
  int mcode, mtot;
  int pa [6] = '{0, 1, 4, 4, 4, 4};
  int pb [6] = '{3, 2, 0, 1, 2, 3};

  intersection_traffic_model #(.QW(QW), .START_DELAY(SD), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .arrive(arrive),
    .e_str_light(lt[0]), .w_str_light(lt[1]), .e_left_light(lt[2]),
    .w_left_light(lt[3]), .ns_light(lt[4]),
    .e_str_sensor(e_str_sensor), .w_str_sensor(w_str_sensor),
    .e_left_sensor(e_left_sensor), .w_left_sensor(w_left_sensor), .ns_sensor(ns_sensor),
    .q_count(q_count), .departed_total(departed_total), .overflow(overflow),
    .conflict_err(conflict_err), .conflict_code(conflict_code),
    .seq_err(seq_err), .starve(starve)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input int p, input int c);
    return (p == c && p != 3) || (p == R && c == G) || (p == G && c == Y) || (p == Y && c == R);
  endfunction

  function automatic logic [4:0] sens();
    return {ns_sensor, w_left_sensor, e_left_sensor, w_str_sensor, e_str_sensor};
  endfunction

  task automatic model_update();
    bit nr [5];
    int dep, nq, dep_n;
    if (!reset) begin
      for (int i = 0; i < 5; i++) begin
        mq[i] = 0; mg[i] = 0; mw[i] = 0; mprev[i] = R;
        movf[i] = 0; mseq[i] = 0; mstarve[i] = 0;
      end
      mcerr = 0; mcode = 0; mtot = 0;
      return;
    end
    for (int i = 0; i < 5; i++) nr[i] = (lt[i] == Y) || (lt[i] == G);
    if (!mcerr)
      for (int p = 0; p < 6; p++)
        if (!mcerr && nr[pa[p]] && nr[pb[p]]) begin mcerr = 1; mcode = p; end
    dep_n = 0;
    for (int i = 0; i < 5; i++) begin
      dep = (lt[i] == G && mg[i] >= SD && mq[i] > 0) ? 1 : 0;
      if (!legal(mprev[i], int'(lt[i]))) mseq[i] = 1;
      if (mw[i] == MW) mstarve[i] = 1;
      mw[i] = (mq[i] > 0 && lt[i] == R) ? ((mw[i] + 1 > MW) ? MW : mw[i] + 1) : 0;
      nq = mq[i] + int'(arrive[i]) - dep;
      if (nq > QMAX) begin nq = QMAX; movf[i] = 1; end
      mq[i] = nq;
      mg[i] = (lt[i] == G) ? ((mg[i] + 1 > SD) ? SD : mg[i] + 1) : 0;
      mprev[i] = int'(lt[i]);
      dep_n += dep;
    end
    mtot = (mtot + dep_n) % 65536;
  endtask

  task automatic check_all();
    logic [4:0] es, eo, eq, est;
    for (int i = 0; i < 5; i++) begin
      chk("q_count", q_count[i*QW +: QW], mq[i]);
      es[i] = (mq[i] != 0); eo[i] = movf[i]; eq[i] = mseq[i]; est[i] = mstarve[i];
    end
    chk("sensors", sens(), es);
    chk("departed_total", departed_total, mtot);
    chk("overflow", overflow, eo);
    chk("seq_err", seq_err, eq);
    chk("starve", starve, est);
    chk("conflict_err", conflict_err, mcerr);
    chk("conflict_code", conflict_code, mcode);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  function automatic logic [1:0] next_color(input logic [1:0] c);
    case (c)
      2'd0:    return 2'd2;
      2'd2:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  initial begin
    reset = 1'b0; arrive = '0;
    for (int i = 0; i < 5; i++) lt[i] = 2'(R);
    step(); step();
    reset = 1'b1; step();
    chk("rst_q", q_count, 0);
    chk("rst_sensors", sens(), 0);
    chk("rst_flags", {overflow, seq_err, starve, conflict_err, conflict_code}, 0);
    chk("rst_total", departed_total, 0);

    // ns queue of 3, then discharge on green
    arrive = 5'b10000; step();
    chk("ns_sensor_rise", ns_sensor, 1);
    step(); step(); arrive = '0;
    chk("ns_q3", q_count[4*QW +: QW], 3);
    lt[4] = 2'(G); step();
    chk("ns_green1_hold", q_count[4*QW +: QW], 3);
    step(); step(); step();
    chk("ns_drained", q_count[4*QW +: QW], 0);
    chk("ns_sensor_low", ns_sensor, 0);
    step(); step();
    chk("ns_departed", departed_total, 3);
    lt[4] = 2'(Y); step(); lt[4] = 2'(R); step();

    // e_str saturation and overflow
    arrive = 5'b00001; repeat (17) step();
    chk("estr_sat", q_count[0 +: QW], 15);
    chk("estr_ovf", overflow[0], 1);
    lt[0] = 2'(G); repeat (3) step();
    chk("estr_hold", q_count[0 +: QW], 15);
    arrive = '0; repeat (16) step();
    chk("estr_drain", q_count[0 +: QW], 0);
    lt[0] = 2'(Y); step(); lt[0] = 2'(R); step();

    // sequence errors
    lt[2] = 2'(G); step(); step(); lt[2] = 2'(R); step();
    chk("seq_eleft", seq_err, 5'b00100);
    lt[0] = 2'(G); step(); lt[0] = 2'(Y); step(); step(); lt[0] = 2'(R); step();
    chk("seq_estr_legal", seq_err[0], 0);

    // conflicts
    lt[3] = 2'(G); step();
    chk("conf_none", conflict_err, 0);
    lt[3] = 2'(Y); lt[0] = 2'(G); step();
    chk("conf_err", conflict_err, 1);
    chk("conf_code", conflict_code, 0);
    lt[3] = 2'(R); lt[0] = 2'(Y); step(); lt[0] = 2'(R); step();
    lt[4] = 2'(G); lt[2] = 2'(G); step();
    chk("conf_code_kept", conflict_code, 0);
    lt[4] = 2'(Y); lt[2] = 2'(Y); step(); lt[4] = 2'(R); lt[2] = 2'(R); step();

    // starvation timing
    reset = 1'b0; step(); reset = 1'b1;
    arrive = 5'b00010; step(); arrive = '0;
    repeat (8) step();
    chk("starve_early", starve[1], 0);
    step();
    chk("starve_set", starve[1], 1);
    reset = 1'b0; step(); reset = 1'b1;
    arrive = 5'b00010; step(); arrive = '0;
    repeat (5) step();
    lt[1] = 2'(G); step(); step(); lt[1] = 2'(Y); step(); lt[1] = 2'(R);
    repeat (10) step();
    chk("starve_green_clear", starve[1], 0);

    // randomized traffic and light sequences
    for (int n = 0; n < 2000; n++) begin
      reset  = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      arrive = 5'($urandom & $urandom);
      for (int i = 0; i < 5; i++) begin
        int r;
        r = $urandom_range(0, 31);
        if (r == 0)     lt[i] = 2'($urandom_range(0, 3));
        else if (r < 8) lt[i] = next_color(lt[i]);
      end
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
